keccak_msg_feeder: RTL and testbench
====================================

# keccak_msg_feeder

Input-side companion to the hash output writer. Accepts a byte-counted message word stream and delivers it to the Keccak core as 32-bit words grouped into rate-sized blocks. Appends FIPS-202 padding on the fly: domain byte 0x06 for SHA3 or 0x1F for SHAKE, zero fill, and 0x80 in the final byte of the block. Sits between the message source (testbench file reader or DMA) and the core's `dt_i` port.

## Interface
Parameters:
- `DW`, 32, data word width; only 32 is supported.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmode` in 3: mode. 0 SHA3-224, 1 SHA3-256, 2 SHA3-384, 3 SHA3-512, 4 SHAKE128, 5 SHAKE256. Sampled on `start`.
- `start` in 1: one-cycle pulse that begins a message.
- `s_data` in 32: message word, little-endian (byte 0 = bits 7:0).
- `s_valid` / `s_ready` in / out 1: source handshake.
- `s_last` in 1: final message word.
- `s_nbytes` in 3: valid bytes in the `s_last` word, 0..4. The value 0 is legal only with `s_last`, and encodes an empty tail or empty message. Ignored when `s_last`=0.
- `dt_o` out 32: word to the core.
- `dt_valid` / `dt_ready` out / in 1: core handshake.
- `blk_last` out 1: `dt_o` is the last word of a rate block.
- `msg_last` out 1: `dt_o` is the last word of the message, including padding.
- `busy` out 1: a message is in progress.
- `done` out 1: one-cycle pulse after the `msg_last` word is accepted.
- `err` out 1: sticky. Set when `start` arrives with `cmode` of 6 or 7. Cleared by the next valid `start`.

## Operation
- Rate in words: 36 / 34 / 26 / 18 / 42 / 34 for modes 0..5.
- States:
  - IDLE: waits for `start`. A valid `cmode` latches the mode, clears `cnt`, and moves to MSG. An invalid `cmode` sets `err` and stays in IDLE.
  - MSG: passes words through.
  - PAD: emits generated pad words.
  - FIN: pulses `done`, then returns to IDLE.
- Word counter `cnt` (6 bits) increments on each `dt` handshake and wraps to 0 after `rate-1`. `blk_last` = (`cnt` == `rate-1`).
- Last-word merge when `n` = `s_nbytes` < 4:
  - The output word is the data masked to the low `n` bytes, OR'd with the domain byte at byte `n`.
  - If the word is also `blk_last`, 0x80 is OR'd into byte 3, and `msg_last` is set.
  - Otherwise the block moves to PAD.
- When `n` = 4, the data passes unchanged and the block moves to PAD with the domain byte pending.
- PAD:
  - The first pad word carries the pending domain byte at byte 0, if any. Remaining words are zero.
  - The `blk_last` word gets 0x80 in byte 3 and `msg_last`.
  - A domain byte and 0x80 landing in the same word are OR'd together, e.g. 0x80000006.
- A message ending exactly on a block boundary with `n` = 4 produces one full extra pad block.
- `start` while `busy` is ignored. The source's words are not consumed outside MSG.

## Timing
- Reset values:
  - `dt_valid`, `s_ready`, `blk_last`, `msg_last`, `busy`, `done`, `err`: 0.
  - `dt_o`: 0.
  - State: IDLE. `cnt`: 0.
- `dt_o`, `dt_valid`, `blk_last` and `msg_last` are registered. Latency from the source handshake to `dt_valid` is 1 cycle.
- `s_ready` = (state == MSG) && (!`dt_valid` || `dt_ready`). This sustains full throughput of one word per cycle.
- Output hold: while `dt_valid` && !`dt_ready`, the outputs hold stable.
- `busy` is high from the cycle after `start` until `done`.
- `done` is asserted the cycle after the `msg_last` handshake.
- PAD emits one word per cycle subject to `dt_ready`.
- An asynchronous reset mid-message aborts the message: all state clears and no `done` is produced.

## Structure
- `keccak_pkg` holds:
  - the `cmode_e` enum;
  - function `rate_words(cmode_e)`;
  - constants `DOM_SHA3`=8'h06, `DOM_SHAKE`=8'h1F, `PAD_END`=8'h80.
- This package is shared with the output writer, which uses it for digest lengths.
- Sub-module `keccak_pad_merge`: combinational. Inputs are data, n, domain, domain-pending and is-blk-last. Output is the merged word. It is used by both MSG and PAD.
- The FSM and counter live in the top module.

## Test plan
- SHA3-256, empty message (one `s_last` word with `s_nbytes`=0):
  - Required: 34 words. Word 0 = 0x00000006, words 1..32 = 0, word 33 = 0x80000000.
  - `blk_last` and `msg_last` on word 33, then `done` one cycle later.
- SHAKE128, "abc" (`s_data`=0x00636261, `s_nbytes`=3):
  - Required: word 0 = 0x1F636261, then 40 zero words, then 0x80000000. 42 words total.
- SHA3-512, 18 full words:
  - Required: 18 data words with `blk_last` on the 18th.
  - Then a pad block: 0x00000006, 16 zero words, 0x80000000 with `msg_last`.
- SHA3-512, 17 full words plus a last word 0x00CCBBAA with `s_nbytes`=3:
  - Required: word 17 = 0x86CCBBAA, with `blk_last` and `msg_last` both set.
- Backpressure: toggle `dt_ready` randomly during the SHA3-224 "abc" case.
  - Required: `dt_o` stays stable while stalled, no words are lost or duplicated, and the sequence matches the stall-free run.
- Error and reset cases:
  - `start` with `cmode`=7 → `err`=1 and `busy`=0.
  - `rst_n` asserted mid-PAD → all outputs 0 and the next message is correct.

Source files
------------

// File: rtl/keccak_pkg.sv
// keccak_pkg: definitions shared by the Keccak message feeder and the hash
// output writer.
//   cmode_e        - hash mode selector (SHA3-224..512, SHAKE128/256)
//   rate_words()   - rate block length in 32-bit words for a mode
//   DOM_SHA3/DOM_SHAKE/PAD_END - FIPS-202 padding bytes
package keccak_pkg;

    typedef enum logic [2:0] {
        SHA3_224 = 3'd0,
        SHA3_256 = 3'd1,
        SHA3_384 = 3'd2,
        SHA3_512 = 3'd3,
        SHAKE128 = 3'd4,
        SHAKE256 = 3'd5
    } cmode_e;

    localparam logic [7:0] DOM_SHA3  = 8'h06;
    localparam logic [7:0] DOM_SHAKE = 8'h1F;
    localparam logic [7:0] PAD_END   = 8'h80;

    function automatic logic [5:0] rate_words(cmode_e mode);
        case (mode)
            SHA3_224: rate_words = 6'd36;
            SHA3_256: rate_words = 6'd34;
            SHA3_384: rate_words = 6'd26;
            SHA3_512: rate_words = 6'd18;
            SHAKE128: rate_words = 6'd42;
            SHAKE256: rate_words = 6'd34;
            default:  rate_words = 6'd34;
        endcase
    endfunction

endpackage

// File: rtl/keccak_msg_feeder_if.sv
// keccak_msg_feeder_if: source and core stream signals of the message feeder.
//   s_data/s_valid/s_ready/s_last/s_nbytes - byte-counted message word stream
//   dt_o/dt_valid/dt_ready/blk_last/msg_last - padded word stream to the core
// Modports: slave = the feeder, master = the environment around it.
interface keccak_msg_feeder_if #(
    parameter int DW = 32
);
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          s_last;
    logic [2:0]    s_nbytes;
    logic [DW-1:0] dt_o;
    logic          dt_valid;
    logic          dt_ready;
    logic          blk_last;
    logic          msg_last;

    modport slave (
        input  s_data, s_valid, s_last, s_nbytes, dt_ready,
        output s_ready, dt_o, dt_valid, blk_last, msg_last
    );

    modport master (
        output s_data, s_valid, s_last, s_nbytes, dt_ready,
        input  s_ready, dt_o, dt_valid, blk_last, msg_last
    );
endinterface

// File: rtl/keccak_pad_merge.sv
// keccak_pad_merge: combinational padding merge for one 32-bit word.
//   data     in  - message word (little-endian bytes)
//   n        in  - number of message bytes kept (4 or more keeps all)
//   domain   in  - domain separation byte
//   dom_pend in  - place the domain byte at byte n (only when n < 4)
//   blk_end  in  - OR the 0x80 end marker into byte 3
//   word     out - merged word
module keccak_pad_merge
    import keccak_pkg::*;
(
    input  logic [31:0] data,
    input  logic [2:0]  n,
    input  logic [7:0]  domain,
    input  logic        dom_pend,
    input  logic        blk_end,
    output logic [31:0] word
);
    logic [31:0] mask;

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (3'(i) < n) mask[i*8 +: 8] = 8'hFF;
        end
        word = data & mask;
        if (dom_pend && (n < 3'd4)) begin
            word = word | ({24'd0, domain} << {n[1:0], 3'b000});
        end
        if (blk_end) word[31:24] = word[31:24] | PAD_END;
    end
endmodule

// File: rtl/keccak_msg_feeder.sv
// keccak_msg_feeder: turns a byte-counted message word stream into rate-sized
// blocks of 32-bit words for the Keccak core, appending FIPS-202 padding.
//   clk, rst_n  - clock, asynchronous active-low reset
//   cmode       - hash mode, sampled on start (6/7 rejected with err)
//   start       - one-cycle pulse starting a message
//   bus         - source and core streams (keccak_msg_feeder_if.slave)
//   busy        - message in progress
//   done        - one-cycle pulse after the msg_last word is accepted
//   err         - sticky invalid-mode flag, cleared by the next valid start
module keccak_msg_feeder
    import keccak_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          cmode,
    input  logic                start,
    keccak_msg_feeder_if.slave  bus,
    output logic                busy,
    output logic                done,
    output logic                err
);
    typedef enum logic [1:0] {IDLE, MSG, PAD, FIN} state_e;

    state_e        state_q, state_d;
    cmode_e        mode_q, mode_d;
    logic [5:0]    cnt_q, cnt_d;
    logic          dom_pend_q, dom_pend_d;
    logic [DW-1:0] dt_o_q, dt_o_d;
    logic          dt_valid_q, dt_valid_d;
    logic          blk_last_q, blk_last_d;
    logic          msg_last_q, msg_last_d;
    logic          err_q, err_d;

    logic          can_load, at_blk_end, short_last;
    logic [7:0]    domain;
    logic [31:0]   m_data, merged;
    logic [2:0]    m_n;
    logic          m_dom_pend, m_blk_end;

    assign can_load   = !dt_valid_q || bus.dt_ready;
    assign at_blk_end = (cnt_q == rate_words(mode_q) - 6'd1);
    assign short_last = bus.s_last && (bus.s_nbytes < 3'd4);
    assign domain     = ((mode_q == SHAKE128) || (mode_q == SHAKE256)) ? DOM_SHAKE : DOM_SHA3;

    // MSG feeds the source word; PAD feeds an all-zero word.
    always_comb begin
        m_data     = '0;
        m_n        = 3'd0;
        m_dom_pend = dom_pend_q;
        m_blk_end  = at_blk_end;
        if (state_q == MSG) begin
            m_data     = bus.s_data;
            m_n        = bus.s_last ? bus.s_nbytes : 3'd4;
            m_dom_pend = short_last;
            m_blk_end  = short_last && at_blk_end;
        end
    end

    keccak_pad_merge u_merge (
        .data     (m_data),
        .n        (m_n),
        .domain   (domain),
        .dom_pend (m_dom_pend),
        .blk_end  (m_blk_end),
        .word     (merged)
    );

    // cnt advances when a word enters the output register; since every loaded
    // word is later accepted, this yields the same blk_last sequence as
    // counting core handshakes.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        dom_pend_d = dom_pend_q;
        dt_o_d     = dt_o_q;
        dt_valid_d = dt_valid_q;
        blk_last_d = blk_last_q;
        msg_last_d = msg_last_q;
        err_d      = err_q;

        if (can_load) begin
            dt_valid_d = 1'b0;
            blk_last_d = 1'b0;
            msg_last_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cmode <= 3'd5) begin
                        mode_d     = cmode_e'(cmode);
                        cnt_d      = '0;
                        dom_pend_d = 1'b0;
                        err_d      = 1'b0;
                        state_d    = MSG;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            MSG: begin
                if (bus.s_valid && can_load) begin
                    dt_o_d     = merged;
                    dt_valid_d = 1'b1;
                    blk_last_d = at_blk_end;
                    cnt_d      = at_blk_end ? '0 : cnt_q + 6'd1;
                    if (bus.s_last) begin
                        if (short_last && at_blk_end) begin
                            msg_last_d = 1'b1;
                            state_d    = FIN;
                        end else begin
                            dom_pend_d = !short_last;
                            state_d    = PAD;
                        end
                    end
                end
            end
            PAD: begin
                if (can_load) begin
                    dt_o_d     = merged;
                    dt_valid_d = 1'b1;
                    blk_last_d = at_blk_end;
                    cnt_d      = at_blk_end ? '0 : cnt_q + 6'd1;
                    dom_pend_d = 1'b0;
                    if (at_blk_end) begin
                        msg_last_d = 1'b1;
                        state_d    = FIN;
                    end
                end
            end
            // FIN holds until the msg_last word has been taken; done is the
            // cycle in FIN with the output register empty.
            FIN: begin
                if (!dt_valid_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= SHA3_224;
            cnt_q      <= '0;
            dom_pend_q <= 1'b0;
            dt_o_q     <= '0;
            dt_valid_q <= 1'b0;
            blk_last_q <= 1'b0;
            msg_last_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            dom_pend_q <= dom_pend_d;
            dt_o_q     <= dt_o_d;
            dt_valid_q <= dt_valid_d;
            blk_last_q <= blk_last_d;
            msg_last_q <= msg_last_d;
            err_q      <= err_d;
        end
    end

    assign bus.s_ready  = (state_q == MSG) && can_load;
    assign bus.dt_o     = dt_o_q;
    assign bus.dt_valid = dt_valid_q;
    assign bus.blk_last = blk_last_q;
    assign bus.msg_last = msg_last_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == FIN) && !dt_valid_q;
    assign err          = err_q;
endmodule

// File: tb/tb_keccak_msg_feeder.sv
// tb_keccak_msg_feeder: table-driven bench for keccak_msg_feeder. Each table
// row is a message (mode, full words, tail word, tail byte count) with
// hand-computed total length and one hand-computed key word; every output
// word is also checked against a byte-level FIPS-202 padding model.
module tb_keccak_msg_feeder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] cmode;
    logic       start;
    logic       busy, done, err;

    keccak_msg_feeder_if #(.DW(32)) bus ();

    keccak_msg_feeder #(.DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cmode (cmode),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  mode;
        int unsigned n_full;
        logic [31:0] last_data;
        logic [2:0]  last_n;
        int unsigned exp_total;
        int unsigned chk_idx;
        logic [31:0] chk_word;
        bit          stall;
    } vec_t;

    vec_t        tab [10];
    int unsigned rate_tab [6] = '{36, 34, 26, 18, 42, 34};
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] full_word(input int unsigned i);
        return 32'hA5C30000 | 32'(i * 32'h0101);
    endfunction

    task automatic run_case(input int unsigned c, input vec_t v);
        logic [7:0]  b [0:1023];
        logic [31:0] expw [0:255];
        logic [31:0] got_key;
        logic [34:0] prev_vec;
        int unsigned rate, rb, len, tot, nrec, src_idx, cyc;
        bit          src_acc, prev_stall, last_prev, fin;

        // Byte-level padding model.
        rate = rate_tab[v.mode];
        rb   = rate * 4;
        len  = v.n_full * 4 + v.last_n;
        tot  = ((len + rb) / rb) * rb;
        for (int unsigned k = 0; k < 1024; k++) b[k] = 8'h00;
        for (int unsigned w = 0; w < v.n_full; w++) begin
            logic [31:0] fw;
            fw = full_word(w);
            for (int unsigned k = 0; k < 4; k++) b[w*4+k] = fw[k*8 +: 8];
        end
        for (int unsigned k = 0; k < v.last_n; k++) b[v.n_full*4+k] = v.last_data[k*8 +: 8];
        b[len]     = (v.mode >= 3'd4) ? 8'h1F : 8'h06;
        b[tot-1]   = b[tot-1] | 8'h80;
        for (int unsigned w = 0; w < tot / 4; w++)
            expw[w] = {b[w*4+3], b[w*4+2], b[w*4+1], b[w*4]};

        @(negedge clk);
        cmode = v.mode;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        src_idx = 0;
        bus.s_valid  = 1'b1;
        bus.s_last   = (v.n_full == 0);
        bus.s_data   = (v.n_full == 0) ? v.last_data : full_word(0);
        bus.s_nbytes = (v.n_full == 0) ? v.last_n : 3'd4;
        #1;
        chk($sformatf("c%0d_busy_after_start", c), 64'(busy), 64'd1);
        chk($sformatf("c%0d_err_clear", c), 64'(err), 64'd0);

        nrec = 0; cyc = 0; src_acc = 0; prev_stall = 0; last_prev = 0; fin = 0;
        got_key = 32'hxxxxxxxx;
        prev_vec = '0;
        while (!fin && cyc < 600) begin
            if (src_acc) begin
                src_idx++;
                if (src_idx < v.n_full) begin
                    bus.s_data = full_word(src_idx);
                end else if (src_idx == v.n_full) begin
                    bus.s_data   = v.last_data;
                    bus.s_last   = 1'b1;
                    bus.s_nbytes = v.last_n;
                end else begin
                    bus.s_valid = 1'b0;
                    bus.s_last  = 1'b0;
                end
            end
            src_acc = 0;
            bus.dt_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            chk($sformatf("c%0d_done_cyc%0d", c, cyc), 64'(done), 64'(last_prev));
            if (last_prev) begin
                fin = 1;
            end else begin
                if (prev_stall)
                    chk($sformatf("c%0d_hold_cyc%0d", c, cyc),
                        64'({bus.dt_valid, bus.blk_last, bus.msg_last, bus.dt_o}), 64'(prev_vec));
                prev_stall = bus.dt_valid && !bus.dt_ready;
                prev_vec   = {bus.dt_valid, bus.blk_last, bus.msg_last, bus.dt_o};
                if (bus.dt_valid && bus.dt_ready) begin
                    if (nrec < tot / 4)
                        chk($sformatf("c%0d_word%0d", c, nrec),
                            64'({bus.blk_last, bus.msg_last, bus.dt_o}),
                            64'({(nrec % rate) == rate - 1, nrec == tot / 4 - 1, expw[nrec]}));
                    if (nrec == v.chk_idx) got_key = bus.dt_o;
                    if (bus.msg_last) last_prev = 1;
                    nrec++;
                end
                src_acc = bus.s_valid && bus.s_ready;
                @(negedge clk);
            end
            cyc++;
        end
        if (!fin) chk($sformatf("c%0d_timeout", c), 64'd0, 64'd1);
        chk($sformatf("c%0d_total_words", c), 64'(nrec), 64'(v.exp_total));
        chk($sformatf("c%0d_key_word", c), 64'(got_key), 64'(v.chk_word));
        chk($sformatf("c%0d_src_consumed", c), 64'(src_idx), 64'(v.n_full + 1));
        bus.dt_ready = 1'b1;
        @(negedge clk);
        #1;
        chk($sformatf("c%0d_idle_after_done", c), 64'({busy, done}), 64'd0);
    endtask

    initial begin
        //           mode  full  tail data      n   total key  key word      stall
        tab[0] = '{3'd1,  0, 32'h00000000, 3'd0, 34,  0, 32'h00000006, 1'b0}; // SHA3-256 empty
        tab[1] = '{3'd4,  0, 32'h00636261, 3'd3, 42,  0, 32'h1F636261, 1'b0}; // SHAKE128 "abc"
        tab[2] = '{3'd3, 17, 32'hA5C31111, 3'd4, 36, 18, 32'h00000006, 1'b0}; // SHA3-512 18 words
        tab[3] = '{3'd3, 17, 32'h00CCBBAA, 3'd3, 18, 17, 32'h86CCBBAA, 1'b0}; // SHA3-512 merge at end
        tab[4] = '{3'd0,  0, 32'h00636261, 3'd3, 36,  0, 32'h06636261, 1'b0}; // SHA3-224 "abc"
        tab[5] = '{3'd0,  0, 32'h00636261, 3'd3, 36, 35, 32'h80000000, 1'b1}; // same, backpressure
        tab[6] = '{3'd2,  4, 32'h11223344, 3'd4, 26,  5, 32'h00000006, 1'b1}; // SHA3-384 full tail
        tab[7] = '{3'd5,  2, 32'hDEADBEAB, 3'd1, 34,  2, 32'h00001FAB, 1'b0}; // SHAKE256 1-byte tail
        tab[8] = '{3'd2,  3, 32'hFFFFFFFF, 3'd0, 26,  3, 32'h00000006, 1'b0}; // empty tail
        tab[9] = '{3'd3, 17, 32'h12345678, 3'd0, 18, 17, 32'h80000006, 1'b0}; // dom+end same word

        rst_n = 1'b0; cmode = 3'd0; start = 1'b0;
        bus.s_data = '0; bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_nbytes = 3'd0;
        bus.dt_ready = 1'b1;
        #3;
        chk("reset_outputs",
            64'({bus.dt_o, bus.dt_valid, bus.s_ready, bus.blk_last, bus.msg_last, busy, done, err}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int unsigned c = 0; c < 10; c++) run_case(c, tab[c]);

        // Invalid mode: err set, stays idle.
        @(negedge clk);
        cmode = 3'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("err_set", 64'({err, busy, bus.dt_valid}), 64'b100);
        run_case(10, tab[0]);

        // Reset in the middle of PAD, with an ignored start while busy.
        @(negedge clk);
        cmode = 3'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.s_valid = 1'b1; bus.s_last = 1'b1; bus.s_nbytes = 3'd0; bus.s_data = 32'hFFFFFFFF;
        bus.dt_ready = 1'b1;
        #1;
        if (bus.s_ready) begin
            @(negedge clk);
            bus.s_valid = 1'b0; bus.s_last = 1'b0;
        end else begin
            chk("rst_seq_s_ready", 64'(bus.s_ready), 64'd1);
        end
        for (int unsigned k = 0; k < 10; k++) begin
            @(negedge clk);
            cmode = 3'd7;
            start = (k == 4);
        end
        start = 1'b0;
        #1;
        chk("busy_start_ignored", 64'({err, busy, bus.dt_valid, bus.s_ready}), 64'b0110);
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_pad",
            64'({bus.dt_o, bus.dt_valid, bus.s_ready, bus.blk_last, bus.msg_last, busy, done, err}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_case(11, tab[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
